// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 block sequencer.
package sha256_pkg;

  localparam int unsigned BLOCK_BYTES = 64;
  localparam int unsigned LEN_POS     = 56;
  localparam logic [7:0]  PAD_BYTE    = 8'h80;

  // Byte positions within a block, sized to match the packer position counter.
  localparam logic [6:0] POS_LAST = 7'(BLOCK_BYTES - 1);
  localparam logic [6:0] POS_LEN  = 7'(LEN_POS);
  localparam logic [6:0] POS_FULL = 7'(BLOCK_BYTES);

  typedef enum logic [3:0] {
    IDLE,
    LOAD,
    PAD,
    ZERO,
    LEN_HI,
    LEN_LO,
    START,
    WAIT,
    DONE
  } seq_state_t;

  // Where the sequencer resumes once the core reports a block compressed.
  typedef enum logic [1:0] {
    RES_LOAD,
    RES_PAD,
    RES_ZERO,
    RES_DONE
  } resume_t;

  // Byte position of the next word boundary after the word holding pos.
  function automatic logic [6:0] next_word_pos(input logic [6:0] pos);
    return {pos[6:2], 2'b00} + 7'd4;
  endfunction

endpackage

// File: rtl/sha256_word_packer.sv
// Packs bytes big-endian into 32-bit words and issues block-buffer writes.
// Tracks the byte position inside the current 64-byte block.
module sha256_word_packer
  import sha256_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_data,
  input  logic        byte_flush,
  input  logic        word_en,
  input  logic [31:0] word_data,
  output logic [6:0]  pos,
  output logic        wr_en,
  output logic [3:0]  wr_idx,
  output logic [31:0] wr_data
);

  logic [31:0] acc;
  logic [31:0] merged;

  // Place the incoming byte into its lane; later lanes are still zero.
  always_comb begin
    merged = acc;
    case (pos[1:0])
      2'd0:    merged[31:24] = byte_data;
      2'd1:    merged[23:16] = byte_data;
      2'd2:    merged[15:8]  = byte_data;
      default: merged[7:0]   = byte_data;
    endcase
  end

  // Accumulate bytes, emit full or flushed words, and advance the position.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pos     <= '0;
      acc     <= '0;
      wr_en   <= 1'b0;
      wr_idx  <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= 1'b0;
      if (clear) begin
        pos <= '0;
        acc <= '0;
      end else if (word_en) begin
        wr_en   <= 1'b1;
        wr_idx  <= pos[5:2];
        wr_data <= word_data;
        pos     <= pos + 7'd4;
        acc     <= '0;
      end else if (byte_en) begin
        if (byte_flush || (pos[1:0] == 2'd3)) begin
          // A flush rounds the position up to the next word boundary.
          wr_en   <= 1'b1;
          wr_idx  <= pos[5:2];
          wr_data <= merged;
          acc     <= '0;
          pos     <= next_word_pos(pos);
        end else begin
          acc <= merged;
          pos <= pos + 7'd1;
        end
      end
    end
  end

endmodule

// File: rtl/sha256_block_sequencer.sv
// Streams message bytes into a SHA-256 core's 16-word block buffer, applies
// the standard padding and 64-bit length trailer, and sequences the core
// block by block until the final block has been compressed.
module sha256_block_sequencer
  import sha256_pkg::*;
#(
  parameter int unsigned LEN_W = 29
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        wr_en,
  output logic [3:0]  wr_idx,
  output logic [31:0] wr_data,
  output logic        blk_start,
  output logic        blk_first,
  input  logic        core_busy,
  input  logic        core_done,
  output logic        msg_done,
  output logic        busy
);

  seq_state_t       state;
  resume_t          resume;
  logic             rdy_q;
  logic             first_q;
  logic [LEN_W-1:0] byte_cnt;
  logic [63:0]      bitlen;

  logic             accept;
  logic [6:0]       pos;
  logic [6:0]       pad_pos_next;
  logic [6:0]       zero_pos_next;

  logic             pk_clear;
  logic             pk_byte_en;
  logic [7:0]       pk_byte_data;
  logic             pk_flush;
  logic             pk_word_en;
  logic [31:0]      pk_word_data;

  // Byte acceptance handshake and message bit length.
  always_comb begin
    in_ready = rdy_q && ((state == IDLE) || (state == LOAD)) && !core_busy;
    accept   = in_valid && in_ready;
    bitlen   = '0;
    bitlen[LEN_W+2:0] = {byte_cnt, 3'b000};
    pad_pos_next  = next_word_pos(pos);
    zero_pos_next = pos + 7'd4;
  end

  // Steer accepted bytes, the pad byte and zero/length words into the packer.
  always_comb begin
    pk_clear     = ((state == WAIT) && core_done) || (state == DONE);
    pk_byte_en   = accept || ((state == PAD) && !core_busy);
    pk_byte_data = (state == PAD) ? PAD_BYTE : in_data;
    pk_flush     = (state == PAD);
    pk_word_en   = ((state == ZERO) || (state == LEN_HI) || (state == LEN_LO)) && !core_busy;
    pk_word_data = '0;
    if (state == LEN_HI) pk_word_data = bitlen[63:32];
    if (state == LEN_LO) pk_word_data = bitlen[31:0];
  end

  sha256_word_packer u_packer (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (pk_clear),
    .byte_en    (pk_byte_en),
    .byte_data  (pk_byte_data),
    .byte_flush (pk_flush),
    .word_en    (pk_word_en),
    .word_data  (pk_word_data),
    .pos        (pos),
    .wr_en      (wr_en),
    .wr_idx     (wr_idx),
    .wr_data    (wr_data)
  );

  // Message sequencing FSM with registered control outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      resume    <= RES_LOAD;
      rdy_q     <= 1'b0;
      first_q   <= 1'b0;
      byte_cnt  <= '0;
      blk_start <= 1'b0;
      blk_first <= 1'b0;
      msg_done  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rdy_q     <= 1'b1;
      blk_start <= 1'b0;
      blk_first <= 1'b0;
      msg_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            byte_cnt <= LEN_W'(1);
            first_q  <= 1'b1;
            busy     <= 1'b1;
            state    <= in_last ? PAD : LOAD;
          end
        end
        LOAD: begin
          if (accept) begin
            byte_cnt <= byte_cnt + LEN_W'(1);
            if (pos == POS_LAST) begin
              // A final byte that fills the block defers padding to the next block.
              resume <= in_last ? RES_PAD : RES_LOAD;
              state  <= START;
            end else if (in_last) begin
              state <= PAD;
            end
          end
        end
        PAD: begin
          if (!core_busy) begin
            if (pad_pos_next == POS_LEN) begin
              state <= LEN_HI;
            end else if (pad_pos_next == POS_FULL) begin
              resume <= RES_ZERO;
              state  <= START;
            end else begin
              state <= ZERO;
            end
          end
        end
        ZERO: begin
          if (!core_busy) begin
            // Stop at the length words, or at block end when the pad overflowed.
            if (zero_pos_next == POS_LEN) begin
              state <= LEN_HI;
            end else if (zero_pos_next == POS_FULL) begin
              resume <= RES_ZERO;
              state  <= START;
            end
          end
        end
        LEN_HI: begin
          if (!core_busy) state <= LEN_LO;
        end
        LEN_LO: begin
          if (!core_busy) begin
            resume <= RES_DONE;
            state  <= START;
          end
        end
        START: begin
          if (!core_busy) begin
            blk_start <= 1'b1;
            blk_first <= first_q;
            first_q   <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (core_done) begin
            case (resume)
              RES_LOAD: state <= LOAD;
              RES_PAD:  state <= PAD;
              RES_ZERO: state <= ZERO;
              RES_DONE: begin
                msg_done <= 1'b1;
                state    <= DONE;
              end
              default:  state <= IDLE;
            endcase
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_block_sequencer.sv
// Scoreboard bench for sha256_block_sequencer: expected padded blocks are
// queued when a message is driven and compared when the DUT starts a block.
module tb_sha256_block_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_ready;
  logic        wr_en;
  logic [3:0]  wr_idx;
  logic [31:0] wr_data;
  logic        blk_start;
  logic        blk_first;
  logic        core_busy;
  logic        core_done;
  logic        msg_done;
  logic        busy;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [7:0]   msg [0:255];
  logic [512:0] exp_q [$];
  logic [31:0]  wbuf [0:15];
  logic [15:0]  wmask = '0;
  int unsigned  msg_cnt = 0;
  int unsigned  blk_cnt = 0;
  logic         mbusy = 1'b0;
  int unsigned  mcnt = 0;
  int unsigned  hold_cnt = 0;
  bit           hold_arm = 1'b0;

  sha256_block_sequencer #(.LEN_W(29)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .wr_en     (wr_en),
    .wr_idx    (wr_idx),
    .wr_data   (wr_data),
    .blk_start (blk_start),
    .blk_first (blk_first),
    .core_busy (core_busy),
    .core_done (core_done),
    .msg_done  (msg_done),
    .busy      (busy)
  );

  initial forever #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor plus core model: samples at negedge, then updates core inputs.
  initial begin : monitor
    logic [512:0] e;
    core_busy = 1'b0;
    core_done = 1'b0;
    forever begin
      @(negedge clk);
      if (hold_cnt > 0) begin
        check_eq("hold_no_start", blk_start, 0);
        check_eq("hold_no_wr", wr_en, 0);
        hold_cnt--;
      end
      if (wr_en) begin
        check_eq("wr_while_busy", core_busy, 0);
        wbuf[wr_idx] = wr_data;
        wmask[wr_idx] = 1'b1;
        if (hold_arm && (wr_idx == 4'd15)) begin
          hold_arm = 1'b0;
          hold_cnt = 20;
        end
      end
      if (blk_start || mbusy) check_eq("ready_in_wait", in_ready, 0);
      if (blk_start) begin
        blk_cnt++;
        check_eq("blk_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          for (int k = 0; k < 16; k++)
            check_eq($sformatf("blk%0d_w%0d", blk_cnt, k), wbuf[k], e[511-32*k -: 32]);
          check_eq($sformatf("blk%0d_first", blk_cnt), blk_first, e[512]);
        end
        check_eq("blk_all_words", wmask, 16'hFFFF);
        wmask = '0;
      end
      if (msg_done) begin
        msg_cnt++;
        check_eq("msg_blocks_left", exp_q.size(), 0);
      end
      core_done = 1'b0;
      if (mcnt > 0) begin
        mcnt--;
        if (mcnt == 0) begin
          mbusy = 1'b0;
          core_done = 1'b1;
        end
      end
      if (blk_start) begin
        mbusy = 1'b1;
        mcnt = 6;
      end
      core_busy = mbusy || (hold_cnt > 0);
    end
  end

  task automatic fill_msg(input int unsigned len, input int unsigned kind);
    for (int unsigned i = 0; i < len; i++) begin
      case (kind)
        0:       msg[i] = 8'h00;
        1:       msg[i] = 8'(i + 1);
        default: msg[i] = 8'($urandom_range(0, 255));
      endcase
    end
  endtask

  // Reference SHA-256 padding: message, 0x80, zeros, 64-bit bit length.
  task automatic push_expected(input int unsigned len);
    int unsigned plen;
    int unsigned p;
    logic [63:0] bits;
    logic [7:0]  v;
    logic [512:0] e;
    plen = ((len + 9 + 63) / 64) * 64;
    bits = 64'(len) * 64'd8;
    for (int unsigned b = 0; b < plen / 64; b++) begin
      e = '0;
      for (int unsigned i = 0; i < 64; i++) begin
        p = b * 64 + i;
        if (p < len)              v = msg[p];
        else if (p == len)        v = 8'h80;
        else if (p >= plen - 8)   v = bits[8*(plen-1-p) +: 8];
        else                      v = 8'h00;
        e[511-8*i -: 8] = v;
      end
      e[512] = (b == 0);
      exp_q.push_back(e);
    end
  endtask

  task automatic drive(input int unsigned len, input int unsigned abort_at, input bit gaps);
    int unsigned idx;
    int unsigned budget;
    bit busy_checked;
    idx = 0;
    budget = 0;
    busy_checked = 1'b0;
    while (idx < len && !(abort_at != 0 && idx >= abort_at)) begin
      @(negedge clk); #1;
      if (idx == 1 && !busy_checked) begin
        check_eq("busy_after_first", busy, 1);
        busy_checked = 1'b1;
      end
      budget++;
      if (budget > 4000) begin
        check_eq("drive_timeout", idx, len);
        break;
      end
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        in_last  = 1'b0;
        continue;
      end
      in_valid = 1'b1;
      in_data  = msg[idx];
      in_last  = (abort_at == 0) && (idx == len - 1);
      if (in_ready) idx++;
    end
    @(negedge clk); #1;
    if (!busy_checked) check_eq("busy_after_first", busy, 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  task automatic wait_done(input int unsigned start_cnt);
    int unsigned n;
    n = 0;
    while (msg_cnt == start_cnt && n < 3000) begin
      @(negedge clk); #2;
      n++;
    end
    check_eq("msg_done_seen", msg_cnt - start_cnt, 1);
    @(negedge clk); #1;
    check_eq("idle_busy", busy, 0);
    check_eq("idle_ready", in_ready, 1);
  endtask

  task automatic run_msg(input int unsigned len, input int unsigned kind, input bit gaps);
    int unsigned start;
    fill_msg(len, kind);
    push_expected(len);
    start = msg_cnt;
    drive(len, 0, gaps);
    wait_done(start);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_ready"}, in_ready, 0);
    check_eq({tag, "_wr_en"}, wr_en, 0);
    check_eq({tag, "_wr_idx"}, wr_idx, 0);
    check_eq({tag, "_wr_data"}, wr_data, 0);
    check_eq({tag, "_blk_start"}, blk_start, 0);
    check_eq({tag, "_blk_first"}, blk_first, 0);
    check_eq({tag, "_msg_done"}, msg_done, 0);
    check_eq({tag, "_busy"}, busy, 0);
  endtask

  initial begin : global_timeout
    #3000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin : stimulus
    int unsigned before_msg;
    int unsigned before_blk;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    reset_n  = 1'b1;
    #1 reset_n = 1'b0;
    #3 check_outputs_zero("reset");
    repeat (2) @(negedge clk);
    #1 reset_n = 1'b1;
    #1 check_eq("release_ready", in_ready, 0);

    // "abc"
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    push_expected(3);
    before_msg = msg_cnt;
    drive(3, 0, 1'b0);
    wait_done(before_msg);

    run_msg(55, 0, 1'b0);
    run_msg(56, 1, 1'b0);
    run_msg(64, 1, 1'b0);
    run_msg(60, 2, 1'b0);
    run_msg(63, 2, 1'b1);
    run_msg(1, 2, 1'b0);
    run_msg(119, 2, 1'b1);
    run_msg(130, 2, 1'b1);

    // Core busy held in START for 20 cycles after the final word write.
    hold_arm = 1'b1;
    run_msg(40, 2, 1'b0);
    check_eq("hold_fired", hold_arm, 0);

    // Reset in the middle of LOAD abandons the message.
    fill_msg(20, 1);
    drive(20, 10, 1'b0);
    @(negedge clk); #1;
    reset_n = 1'b0;
    #1 check_outputs_zero("abort");
    wmask = '0;
    repeat (2) @(negedge clk);
    #1 reset_n = 1'b1;
    #1 check_eq("abort_release_ready", in_ready, 0);
    before_msg = msg_cnt;
    before_blk = blk_cnt;
    repeat (30) @(negedge clk);
    check_eq("no_msg_after_abort", msg_cnt - before_msg, 0);
    check_eq("no_blk_after_abort", blk_cnt - before_blk, 0);

    run_msg(3, 1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha256_block_sequencer.md
SHA256_BLOCK_SEQUENCER -- requirements
Module: sha256_block_sequencer

Interface
REQ-001 SHALL have parameter LEN_W, default 29, meaning message byte-counter width; maximum message is 2^LEN_W-1 bytes.
REQ-002 SHALL have port clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  in  1  message byte valid.
REQ-005 SHALL have port in_data  in  8  message byte, first byte is most significant.
REQ-006 SHALL have port in_last  in  1  qualifies in_valid: final message byte.
REQ-007 SHALL have port in_ready  out  1  byte accepted when in_valid and in_ready are both high.
REQ-008 SHALL have port wr_en  out  1  write strobe into the core's 16-word block buffer.
REQ-009 SHALL have port wr_idx  out  4  word index 0..15.
REQ-010 SHALL have port wr_data  out  32  big-endian packed word.
REQ-011 SHALL have port blk_start  out  1  one-cycle pulse: compress the buffered block.
REQ-012 SHALL have port blk_first  out  1  valid with blk_start: core loads the H0..H7 initial values first.
REQ-013 SHALL have port core_busy  in  1  core compressing; block buffer must not be written.
REQ-014 SHALL have port core_done  in  1  one-cycle pulse: block compressed, hash updated.
REQ-015 SHALL have port msg_done  out  1  one-cycle pulse: final block compressed.
REQ-016 SHALL have port busy  out  1  high from first accepted byte until msg_done.

Function
REQ-017 SHALL use states IDLE, LOAD, PAD, ZERO, LEN_HI, LEN_LO, START, WAIT, DONE.
REQ-018 in_ready SHALL be high only in IDLE/LOAD with core_busy low and fewer than 64 bytes in the current block.
REQ-019 SHALL pack accepted bytes big-endian (first byte in [31:24]); wr_en pulses the cycle after a word's 4th byte, with wr_idx equal to the word position.
REQ-020 SHALL count accepted bytes in an LEN_W-bit counter; the counter wraps silently beyond the maximum (unsupported).
REQ-021 When the 64th byte of a block is accepted without in_last: LOAD->START; after core_done, WAIT->LOAD with the block position cleared.
REQ-022 When in_last is accepted: ->PAD, append byte 0x80 at the next position (one cycle), and write the partial word with its trailing bytes zero.
REQ-023 In ZERO, SHALL write one all-zero word per cycle until word 14 is reached.
REQ-024 If 0x80 lands at byte position 56..63: SHALL zero-fill to word 15, run START/WAIT, then write zero words 0..13 of a second block.
REQ-025 LEN_HI SHALL write word 14 = upper 32 bits of the 64-bit bit length; LEN_LO SHALL write word 15 = lower 32 bits; bit length = byte count x 8.
REQ-026 START SHALL pulse blk_start for one cycle, with blk_first=1 only on a message's first block; SHALL wait in START while core_busy is high.
REQ-027 WAIT SHALL hold until core_done; core_done SHALL be ignored in every other state.
REQ-028 DONE SHALL pulse msg_done for one cycle, then go to IDLE; the next message's first byte may be accepted the following cycle.
REQ-029 Empty messages are unsupported; the minimum message is 1 byte, with in_last on that byte.
REQ-030 wr_en SHALL never be asserted while core_busy is high.

Reset
REQ-031 reset_n low SHALL asynchronously force IDLE and clear the counters and packer.
REQ-032 Reset values: in_ready=0 until the first clock after release, then per REQ-018; wr_en, wr_idx, wr_data, blk_start, blk_first, msg_done and busy all 0.
REQ-033 Reset during an in-flight message SHALL abandon it; no blk_start or msg_done SHALL follow.

Structure
REQ-034 Package sha256_pkg SHALL hold the state enum and constants BLOCK_BYTES=64, LEN_POS=56 and PAD_BYTE=8'h80.
REQ-035 Byte-to-word packing SHALL be the sub-module sha256_word_packer.

Verification
REQ-036 "abc" -> one block; word0=0x61626380, words1-13=0, word14=0, word15=0x00000018; one blk_start with blk_first=1; then msg_done.
REQ-037 55 bytes of 0x00 -> one block; word13=0x00000080, word15=0x000001B8.
REQ-038 56 bytes -> two blocks; block 2 words0-14=0, word15=0x000001C0; blk_first=1 only on block 1.
REQ-039 64 bytes -> two blocks; block 2 word0=0x80000000, word15=0x00000200; in_ready low throughout WAIT.
REQ-040 core_busy held high 20 cycles in START -> no wr_en and no blk_start until release; reset asserted mid-LOAD -> all outputs 0, no msg_done.
